memory_cell_scheduler: RTL and testbench



---
 rtl/esfa_cell_pkg.sv | 52 +++++
 rtl/memory_cell_slot.sv | 26 ++
 rtl/memory_cell_scheduler.sv | 141 ++++++++++++++
 tb/tb_memory_cell_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/esfa_cell_pkg.sv
// Shared definitions for the ESFA cell bank: field widths, tuple layout,
// opcodes and scheduler state encoding.
package esfa_cell_pkg;

  localparam int HW = 4;
  localparam int CW = 4;
  localparam int RW = 4;
  localparam int IW = 8;
  localparam int VW = 16;
  localparam int TW = 3 + HW + CW + RW + 3*IW + VW;

  // Tuple layout, LSB upward: mark, value, index, high, low, rank, eltDef,
  // array_code, handle, arrDef.
  localparam int MARK_BIT = 0;
  localparam int VAL_LSB  = MARK_BIT + 1;
  localparam int IDX_LSB  = VAL_LSB + VW;
  localparam int HIGH_LSB = IDX_LSB + IW;
  localparam int LOW_LSB  = HIGH_LSB + IW;
  localparam int RANK_LSB = LOW_LSB + IW;
  localparam int ELT_BIT  = RANK_LSB + RW;
  localparam int CODE_LSB = ELT_BIT + 1;
  localparam int HND_LSB  = CODE_LSB + CW;
  localparam int ARR_BIT  = HND_LSB + HW;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_LOOKUP = 2'd1;
  localparam logic [1:0] OP_MARK   = 2'd2;
  localparam logic [1:0] OP_SWEEP  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic          id;
    logic [1:0]    op;
    logic [TW-1:0] tuple;
  } req_t;

  function automatic logic [HW-1:0] f_handle(input logic [TW-1:0] t);
    return t[HND_LSB +: HW];
  endfunction

  function automatic logic [IW-1:0] f_index(input logic [TW-1:0] t);
    return t[IDX_LSB +: IW];
  endfunction

  function automatic logic f_free(input logic [TW-1:0] t);
    return !t[ARR_BIT] && !t[ELT_BIT];
  endfunction

endpackage

// File: rtl/memory_cell_slot.sv
// One tuple cell. Clear wins over write, write over mark updates.
module memory_cell_slot
  import esfa_cell_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic          i_set_mark,
  input  logic          i_clr_mark,
  input  logic [TW-1:0] i_wdata,
  output logic [TW-1:0] o_tuple
);

  logic [TW-1:0] r_tuple;

  always_ff @(posedge clk) begin
    if (rst || i_clr)    r_tuple <= '0;
    else if (i_we)       r_tuple <= i_wdata;
    else if (i_set_mark) r_tuple[MARK_BIT] <= 1'b1;
    else if (i_clr_mark) r_tuple[MARK_BIT] <= 1'b0;
  end

  assign o_tuple = r_tuple;

endmodule

// File: rtl/memory_cell_scheduler.sv
// Two-requester round-robin scheduler that scans the cell bank one slot per
// cycle for WRITE/LOOKUP/MARK/SWEEP and returns one response per operation.
module memory_cell_scheduler
  import esfa_cell_pkg::*;
#(
  parameter  int N_CELLS = 8,
  localparam int SW      = $clog2(N_CELLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [3:0]          req_op,
  input  logic [1:0][TW-1:0]  req_tuple,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic                rsp_hit,
  output logic [SW-1:0]       rsp_slot,
  output logic [TW-1:0]       rsp_tuple,
  output logic                busy
);

  logic [1:0]    r_state;
  logic          r_last;
  req_t          r_req;
  logic [SW-1:0] r_idx;
  logic          r_hit;
  logic [SW-1:0] r_slot;
  logic [TW-1:0] r_ltuple;

  logic                       w_gnt_id;
  logic                       w_hs;
  req_t                       w_new;
  logic [N_CELLS-1:0][TW-1:0] w_cells;
  logic [TW-1:0]              w_cur;
  logic                       w_match;
  logic                       w_scan;
  logic [TW-1:0]              w_wdata;
  logic [N_CELLS-1:0]         w_clr, w_we, w_set_mark, w_clr_mark;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    w_gnt_id  = (req_valid == 2'b11) ? ~r_last : req_valid[1];
    req_ready = '0;
    if (r_state == ST_IDLE && !rst && |req_valid)
      req_ready = w_gnt_id ? 2'b10 : 2'b01;
    w_hs      = |(req_valid & req_ready);
    w_new.id    = w_gnt_id;
    w_new.op    = w_gnt_id ? req_op[3:2] : req_op[1:0];
    w_new.tuple = req_tuple[w_gnt_id];
  end

  assign w_scan = (r_state == ST_SCAN);
  assign w_cur  = w_cells[r_idx];

  // Per-op qualifier for the cell under the scan index.
  always_comb begin
    w_match = 1'b0;
    case (r_req.op)
      OP_WRITE:  w_match = f_free(w_cur);
      OP_LOOKUP: w_match = w_cur[ARR_BIT] && w_cur[ELT_BIT] &&
                           f_handle(w_cur) == f_handle(r_req.tuple) &&
                           f_index(w_cur) == f_index(r_req.tuple);
      OP_MARK:   w_match = w_cur[ARR_BIT] &&
                           f_handle(w_cur) == f_handle(r_req.tuple);
      OP_SWEEP:  w_match = w_cur[ARR_BIT] && !w_cur[MARK_BIT];
      default:   w_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_req    <= '0;
      r_idx    <= '0;
      r_hit    <= 1'b0;
      r_slot   <= '0;
      r_ltuple <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_hs) begin
          r_req    <= w_new;
          r_last   <= w_gnt_id;
          r_idx    <= '0;
          r_hit    <= 1'b0;
          r_slot   <= '0;
          r_ltuple <= '0;
          r_state  <= ST_SCAN;
        end
        ST_SCAN: begin
          if (w_match && !r_hit) begin
            r_hit    <= 1'b1;
            r_slot   <= r_idx;
            r_ltuple <= w_cur;
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == SW'(N_CELLS-1)) r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stored WRITE tuple always starts unmarked.
  assign w_wdata = {r_req.tuple[TW-1:1], 1'b0};

  for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
    logic w_sel;
    assign w_sel         = w_scan && (r_idx == SW'(g));
    assign w_clr[g]      = w_sel && r_req.op == OP_SWEEP && w_match;
    assign w_clr_mark[g] = w_sel && r_req.op == OP_SWEEP && !w_match;
    assign w_set_mark[g] = w_sel && r_req.op == OP_MARK && w_match;
    assign w_we[g]       = r_state == ST_RESP && r_req.op == OP_WRITE &&
                           r_hit && r_slot == SW'(g);

    memory_cell_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr[g]),
      .i_we       (w_we[g]),
      .i_set_mark (w_set_mark[g]),
      .i_clr_mark (w_clr_mark[g]),
      .i_wdata    (w_wdata),
      .o_tuple    (w_cells[g])
    );
  end

  always_comb begin
    rsp_valid = (r_state == ST_RESP) && !rst;
    rsp_id    = rsp_valid && r_req.id;
    rsp_hit   = rsp_valid && r_hit;
    rsp_slot  = rsp_hit ? r_slot : '0;
    rsp_tuple = '0;
    if (rsp_hit && r_req.op == OP_WRITE)  rsp_tuple = w_wdata;
    if (rsp_hit && r_req.op == OP_LOOKUP) rsp_tuple = r_ltuple;
    busy      = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_memory_cell_scheduler.sv
// Scoreboard bench: a behavioural bank model predicts each response at
// accept time; a negedge monitor checks grants, busy and responses.
module tb_memory_cell_scheduler;

  localparam int N  = 8;
  localparam int TW = 55;

  typedef struct packed {
    logic        arr;
    logic [3:0]  handle;
    logic [3:0]  code;
    logic        elt;
    logic [3:0]  rank;
    logic [7:0]  low;
    logic [7:0]  high;
    logic [7:0]  index;
    logic [15:0] value;
    logic        mark;
  } tup_t;

  typedef struct { logic [1:0] op; tup_t t; } stim_t;
  typedef struct { int due; logic id; logic hit; logic [2:0] slot; tup_t t; } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [3:0]          req_op;
  logic [1:0][TW-1:0]  req_tuple;
  logic                rsp_valid, rsp_id, rsp_hit;
  logic [2:0]          rsp_slot;
  logic [TW-1:0]       rsp_tuple;
  logic                busy;

  memory_cell_scheduler #(.N_CELLS(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_tuple(req_tuple), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_slot(rsp_slot),
    .rsp_tuple(rsp_tuple), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stim_t sq0[$], sq1[$];
  exp_t  eq[$];
  tup_t  mem[N];
  int    last, free_at, acc_cyc;
  int    checks = 0, errors = 0;
  logic [1:0] acc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic tup_t mk(input int h, input int idx, input int val,
                              input bit a = 1'b1, input bit e = 1'b1);
    tup_t t;
    t = '0;
    t.arr = a; t.elt = e; t.handle = 4'(h); t.index = 8'(idx);
    t.value = 16'(val); t.code = 4'(h + 1); t.rank = 4'd2;
    t.low = 8'h10; t.high = 8'h20;
    return t;
  endfunction

  // Whole-operation effect on the bank, applied at accept time.
  task automatic model_op(input logic [1:0] op, input tup_t t,
                          output logic hit, output logic [2:0] slot, output tup_t rt);
    hit = 1'b0; slot = '0; rt = '0;
    case (op)
      2'd0: begin
        for (int i = 0; i < N; i++)
          if (!hit && !mem[i].arr && !mem[i].elt) begin hit = 1'b1; slot = 3'(i); end
        if (hit) begin rt = t; rt.mark = 1'b0; mem[slot] = rt; end
      end
      2'd1: for (int i = 0; i < N; i++)
        if (!hit && mem[i].arr && mem[i].elt && mem[i].handle == t.handle &&
            mem[i].index == t.index) begin
          hit = 1'b1; slot = 3'(i); rt = mem[i];
        end
      2'd2: for (int i = 0; i < N; i++)
        if (mem[i].arr && mem[i].handle == t.handle) begin
          if (!hit) begin hit = 1'b1; slot = 3'(i); end
          mem[i].mark = 1'b1;
        end
      default: for (int i = 0; i < N; i++)
        if (mem[i].arr && !mem[i].mark) begin
          if (!hit) begin hit = 1'b1; slot = 3'(i); end
          mem[i] = '0;
        end else mem[i].mark = 1'b0;
    endcase
  endtask

  logic [1:0] m_exp;
  int         m_g;
  exp_t       m_e;
  logic       m_hit;
  logic [2:0] m_slot;
  tup_t       m_rt;

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      chk("rsp_valid_in_reset", 64'(rsp_valid), 64'd0);
      eq.delete();
      for (int i = 0; i < N; i++) mem[i] = '0;
      last = 1; free_at = 0; acc_cyc = -100; acc = '0;
    end else begin
      m_exp = '0;
      if (cyc >= free_at && req_valid != 2'b00) begin
        m_g   = (req_valid == 2'b11) ? (last == 1 ? 0 : 1) : (req_valid[1] ? 1 : 0);
        m_exp = 2'(1 << m_g);
      end
      chk("req_ready", 64'(req_ready), 64'(m_exp));
      chk("busy", 64'(busy), 64'(cyc > acc_cyc && cyc <= acc_cyc + 9));
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        m_g = acc[1] ? 1 : 0;
        model_op(req_op[2*m_g +: 2], req_tuple[m_g], m_hit, m_slot, m_rt);
        m_e.due = cyc + 9; m_e.id = m_g[0]; m_e.hit = m_hit;
        m_e.slot = m_slot; m_e.t = m_rt;
        eq.push_back(m_e);
        last = m_g; free_at = cyc + 10; acc_cyc = cyc;
      end
      if (rsp_valid) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected got valid want none (cycle %0d)", cyc);
        end else begin
          m_e = eq.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(m_e.due));
          chk("rsp_id", 64'(rsp_id), 64'(m_e.id));
          chk("rsp_hit", 64'(rsp_hit), 64'(m_e.hit));
          chk("rsp_slot", 64'(rsp_slot), 64'(m_e.slot));
          chk("rsp_tuple", 64'(rsp_tuple), 64'(m_e.t));
        end
      end else if (eq.size() > 0 && eq[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL rsp_missing got none want response due %0d (cycle %0d)", eq[0].due, cyc);
        void'(eq.pop_front());
      end
    end
  end

  // Requester driver: holds a request until its handshake, then presents the next.
  initial begin
    stim_t s;
    req_valid = '0; req_op = '0; req_tuple = '0;
    forever begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && acc[r]) req_valid[r] = 1'b0;
        if (!req_valid[r] && (r == 0 ? sq0.size() : sq1.size()) > 0) begin
          s = (r == 0) ? sq0.pop_front() : sq1.pop_front();
          req_op[2*r +: 2] = s.op;
          req_tuple[r]     = s.t;
          req_valid[r]     = 1'b1;
        end
      end
    end
  end

  task automatic push(input int r, input logic [1:0] op, input tup_t t);
    stim_t s;
    s.op = op; s.t = t;
    if (r == 0) sq0.push_back(s); else sq1.push_back(s);
  endtask

  task automatic drain();
    int n = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || req_valid != 2'b00 ||
            eq.size() > 0 || busy) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout got busy want idle (cycle %0d)", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Allocate then look up, hit and miss.
    push(0, 2'd0, mk(3, 5, 16'hBEEF));
    drain();
    push(1, 2'd1, mk(3, 5, 0));
    push(1, 2'd1, mk(3, 6, 0));
    drain();

    // Contending writers alternate; the bank fills and later writes miss.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      push(0, 2'd0, mk(k, k, 16'h100 + k));
      push(1, 2'd0, mk(8 + k, k, 16'h200 + k));
    end
    drain();

    // Mark and two sweeps, with lookups observing the bank in between.
    pulse_reset();
    push(0, 2'd0, mk(3, 0, 16'hA0));
    push(0, 2'd0, mk(4, 1, 16'hA1));
    push(0, 2'd0, mk(3, 2, 16'hA2));
    push(0, 2'd2, mk(3, 0, 0));
    push(0, 2'd3, mk(0, 0, 0));
    push(0, 2'd1, mk(3, 0, 0));
    push(0, 2'd1, mk(4, 1, 0));
    push(0, 2'd3, mk(0, 0, 0));
    push(0, 2'd1, mk(3, 2, 0));
    push(0, 2'd0, mk(5, 7, 16'hA5));
    drain();

    // Reset in the fourth scan cycle aborts the op and empties the bank.
    push(0, 2'd1, mk(5, 7, 0));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy && n < 50);
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL scan_start_timeout got idle want busy (cycle %0d)", cyc);
    end
    repeat (3) @(posedge clk);
    #1 pulse_reset();
    push(1, 2'd1, mk(5, 7, 0));
    drain();

    // Requests queued on both sides while busy are held, each accepted once.
    push(0, 2'd0, mk(6, 1, 16'h1234));
    push(1, 2'd1, mk(6, 1, 0));
    push(0, 2'd2, mk(6, 0, 0));
    push(1, 2'd3, mk(0, 0, 0));
    drain();

    // Randomized mix over a small handle/index space to force collisions.
    pulse_reset();
    for (int k = 0; k < 90; k++) begin
      tup_t t;
      int   op;
      op = $urandom_range(0, 9);
      op = (op < 4) ? 0 : (op < 7) ? 1 : (op < 9) ? 2 : 3;
      t = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 16'hFFFF),
             ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
      t.mark = 1'($urandom_range(0, 1));
      push($urandom_range(0, 1), 2'(op), t);
      if ($urandom_range(0, 9) == 0) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
